// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the two-port memory arbiter.
//   arb_state_e  - arbiter FSM states (free, or locked to one port)
//   port_idx_t   - index of a bus master (0 = core, 1 = second master)
//   Idle*        - memory-side outputs driven when nothing is granted
//   other_port() - the port that is not the given one
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  typedef logic port_idx_t;

  localparam logic [31:0] IdleWdata      = 32'h0;
  localparam logic [3:0]  IdleWmask      = 4'h0;
  localparam logic        IdleNotWriting = 1'b1;
  localparam logic        IdleReadEn     = 1'b0;

  function automatic port_idx_t other_port(port_idx_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/mem_return_pipe.sv
// mem_return_pipe: carries {valid, owner} for every accepted read through a
// READ_LATENCY-deep delay line and steers the memory read data back to the
// port that issued the read.
//   clock, reset           - clock, asynchronous active-low reset
//   push_valid, push_owner - a read was accepted this cycle, and by which port
//   mem_rdata              - memory read data, valid READ_LATENCY cycles later
//   m0_rvalid, m0_rdata    - read return for port 0
//   m1_rvalid, m1_rdata    - read return for port 1
module mem_return_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push_valid,
  input  port_idx_t   push_owner,
  input  logic [31:0] mem_rdata,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata
);

  logic [READ_LATENCY-1:0] vld_q;
  logic [READ_LATENCY-1:0] own_q;
  logic [31:0]             m0_rdata_q;
  logic [31:0]             m1_rdata_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q[0] <= push_valid;
      own_q[0] <= push_owner;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        vld_q[i] <= vld_q[i-1];
        own_q[i] <= own_q[i-1];
      end
    end
  end

  assign m0_rvalid = vld_q[READ_LATENCY-1] & (own_q[READ_LATENCY-1] == 1'b0);
  assign m1_rvalid = vld_q[READ_LATENCY-1] & (own_q[READ_LATENCY-1] == 1'b1);

  // Capture registers keep the last returned word for each port.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      if (m0_rvalid) m0_rdata_q <= mem_rdata;
      if (m1_rvalid) m1_rdata_q <= mem_rdata;
    end
  end

  // Memory data is only present in the exit cycle, so pass it straight through then.
  assign m0_rdata = m0_rvalid ? mem_rdata : m0_rdata_q;
  assign m1_rdata = m1_rvalid ? mem_rdata : m1_rdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory word port between two bus masters with
// round-robin priority, a bounded lock for atomic sequences, and read data
// returned to the originating port after the memory's fixed read latency.
//   clock, reset                  - clock, asynchronous active-low reset
//   mN_req/we/addr/wdata/wmask    - access request from master N (N = 0, 1)
//   mN_lock                       - keep ownership after this access
//   mN_gnt                        - access accepted this cycle (combinational)
//   mN_rvalid, mN_rdata           - read return to master N
//   mem_addr/wdata/wmask          - word address, data, byte mask to memory
//   mem_not_writing, mem_read_en  - memory strobes (write is active low)
//   mem_rdata                     - memory read data
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 24,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_HOLD     = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wmask,
  input  logic                  m0_lock,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [31:0]           m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wmask,
  input  logic                  m1_lock,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [31:0]           m1_rdata,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  output logic                  mem_not_writing,
  output logic                  mem_read_en,
  input  logic [31:0]           mem_rdata
);

  localparam logic [7:0] MaxHold = 8'(MAX_HOLD);

  arb_state_e state_q;
  port_idx_t  rr_ptr_q;
  logic [7:0] hold_cnt_q;

  logic      any_gnt;
  port_idx_t sel;
  logic      sel_we;
  logic      sel_lock;

  // Byte-offset bits never reach the word-addressed memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[1:0], m1_addr[1:0]};

  // Grant depends only on req, state and rr_ptr; lock is looked at after the grant.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (reset) begin
      unique case (state_q)
        IDLE: begin
          m0_gnt = m0_req & (~m1_req | (rr_ptr_q == 1'b0));
          m1_gnt = m1_req & (~m0_req | (rr_ptr_q == 1'b1));
        end
        OWN0:    m0_gnt = m0_req;
        OWN1:    m1_gnt = m1_req;
        default: ;
      endcase
    end
  end

  assign any_gnt  = m0_gnt | m1_gnt;
  assign sel      = m1_gnt;
  assign sel_we   = sel ? m1_we : m0_we;
  assign sel_lock = sel ? m1_lock : m0_lock;

  always_comb begin
    mem_addr        = '0;
    mem_wdata       = IdleWdata;
    mem_wmask       = IdleWmask;
    mem_not_writing = IdleNotWriting;
    mem_read_en     = IdleReadEn;
    if (any_gnt) begin
      mem_addr  = sel ? m1_addr[ADDR_WIDTH-1:2] : m0_addr[ADDR_WIDTH-1:2];
      mem_wdata = sel ? m1_wdata : m0_wdata;
      if (sel_we) begin
        mem_not_writing = 1'b0;
        mem_wmask       = sel ? m1_wmask : m0_wmask;
      end else begin
        mem_read_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_gnt) begin
            rr_ptr_q <= other_port(sel);
            if (sel_lock) begin
              state_q    <= sel ? OWN1 : OWN0;
              hold_cnt_q <= 8'd1;
            end
          end
        end
        OWN0, OWN1: begin
          // The owner's access in the limit cycle still completes; release follows.
          if ((any_gnt && !sel_lock) || (hold_cnt_q == MaxHold)) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            rr_ptr_q   <= other_port(state_q == OWN1);
          end else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mem_return_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_return_pipe (
    .clock     (clock),
    .reset     (reset),
    .push_valid(any_gnt & ~sel_we),
    .push_owner(sel),
    .mem_rdata (mem_rdata),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata)
  );

endmodule
